// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage access FSM driving a ready-handshaked data port; optional MEM_MISALIGN_CHECK_EN rejects misaligned accesses.
module mem_stage_ctrl #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read_i,
  input  logic         mem_write_i,
  input  logic [N-1:0] addr_i,
  input  logic [N-1:0] wdata_i,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [N-1:0] mem_addr_o,
  output logic [N-1:0] mem_wdata_o,
  input  logic         mem_ready_i,
  input  logic [N-1:0] mem_rdata_i,
  output logic         stall_o,
  output logic [N-1:0] rdata_o,
  output logic         rdata_valid_o,
  output logic         misaligned_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state, w_state_nxt;
  logic r_req, r_we, r_valid;
  logic [N-1:0] r_addr, r_wdata, r_rdata;
  logic w_access, w_mis, w_issue, w_done;
  assign w_access = mem_read_i | mem_write_i;
`ifdef MEM_MISALIGN_CHECK_EN
  assign w_mis = addr_i[1:0] != 2'b00;
`else
  assign w_mis = 1'b0;
`endif
  assign w_issue = (r_state == IDLE) && w_access && !w_mis;
  assign w_done  = (r_state == BUSY) && mem_ready_i;
  always_comb begin
    w_state_nxt = (r_state == IDLE) ? (w_access ? (w_mis ? DONE : BUSY) : IDLE) :
                  (r_state == BUSY) ? (mem_ready_i ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_done && !r_we;
      if (w_issue) begin
        r_req   <= 1'b1;
        r_we    <= mem_write_i;
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
      end
      if (w_done) r_req <= 1'b0;
      if (w_done && !r_we) r_rdata <= mem_rdata_i;
    end
  end
`ifdef MEM_MISALIGN_CHECK_EN
  logic r_mis;
  always_ff @(posedge clk) begin
    if (reset) r_mis <= 1'b0;
    else r_mis <= (r_state == IDLE) && w_access && w_mis;
  end
  assign misaligned_o = r_mis;
`else
  assign misaligned_o = 1'b0;
`endif
  assign stall_o       = ((r_state == IDLE) && w_access) || (r_state == BUSY);
  assign mem_req_o     = r_req;
  assign mem_we_o      = r_we;
  assign mem_addr_o    = r_addr;
  assign mem_wdata_o   = r_wdata;
  assign rdata_o       = r_rdata;
  assign rdata_valid_o = r_valid;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: scoreboard bench for mem_stage_ctrl; expected requests and load data are queued by stimulus and popped by a monitor.
module tb_mem_stage_ctrl;
  logic clk = 1'b0;
  logic reset, mem_read_i, mem_write_i, mem_ready_i;
  logic [31:0] addr_i, wdata_i, mem_rdata_i;
  logic mem_req_o, mem_we_o, stall_o, rdata_valid_o, misaligned_o;
  logic [31:0] mem_addr_o, mem_wdata_o, rdata_o;
  int n_vec = 0, n_err = 0, exp_mis = 0;
  logic [64:0] req_q[$];
  logic [31:0] rd_q[$];
  logic prev_req = 1'b0;
  logic [64:0] held;
  always #5 clk = ~clk;
  mem_stage_ctrl dut (
    .clk(clk), .reset(reset), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .rdata_o(rdata_o),
    .rdata_valid_o(rdata_valid_o), .misaligned_o(misaligned_o)
  );
  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (mem_req_o && !prev_req) begin
      if (req_q.size() == 0) chk("unexpected_req", {mem_we_o, mem_addr_o, mem_wdata_o}, 65'h0);
      else chk("req_fields", {mem_we_o, mem_addr_o, mem_wdata_o}, req_q.pop_front());
      held = {mem_we_o, mem_addr_o, mem_wdata_o};
    end else if (mem_req_o) chk("req_stable", {mem_we_o, mem_addr_o, mem_wdata_o}, held);
    if (rdata_valid_o) begin
      if (rd_q.size() == 0) chk("unexpected_valid", {33'h0, rdata_o}, 65'h0);
      else chk("load_data", {33'h0, rdata_o}, {33'h0, rd_q.pop_front()});
    end
    if (misaligned_o) begin
      chk("mis_expected", 65'(exp_mis > 0), 65'h1);
      if (exp_mis > 0) exp_mis--;
    end
    prev_req = mem_req_o;
  end
  task automatic do_acc(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat, input int lat, input int exp_stall, input logic issue);
    int stalls = 0;
    int c = 0;
    mem_read_i = rd; mem_write_i = wr; addr_i = a; wdata_i = wd; mem_rdata_i = rdat;
    if (issue) begin
      req_q.push_back({wr, a, wd});
      if (rd && !wr) rd_q.push_back(rdat);
    end else exp_mis++;
    while (c < 50) begin
      mem_ready_i = (c == lat);
      @(negedge clk);
      if (!stall_o) break;
      stalls++;
      @(posedge clk); #1;
      c++;
    end
    chk("stall_cycles", 65'(stalls), 65'(exp_stall));
    @(posedge clk); #1;
    mem_read_i = 1'b0; mem_write_i = 1'b0; mem_ready_i = 1'b0;
  endtask
  task automatic chk_reset_vals();
    @(negedge clk);
    chk("rst_req_we_valid_mis", {61'h0, mem_req_o, mem_we_o, rdata_valid_o, misaligned_o}, 65'h0);
    chk("rst_addr_wdata", {1'b0, mem_addr_o, mem_wdata_o}, 65'h0);
    chk("rst_rdata", {33'h0, rdata_o}, 65'h0);
    chk("rst_stall", {64'h0, stall_o}, 65'h0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b0; mem_ready_i = 1'b0;
    addr_i = '0; wdata_i = '0; mem_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset_vals();
    @(posedge clk); #1;
    do_acc(1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 2, 1);
    do_acc(0, 1, 32'h204, 32'h12345678, 32'h55555555, 4, 5, 1);
    chk("store_keeps_rdata", {33'h0, rdata_o}, {33'h0, 32'hDEADBEEF});
    do_acc(1, 0, 32'h40, 32'h0, 32'hCAFEF00D, 2, 3, 1);
    do_acc(0, 1, 32'h44, 32'hA1B2C3D4, 32'h0, 1, 2, 1);
    chk("b2b_rdata", {33'h0, rdata_o}, {33'h0, 32'hCAFEF00D});
    do_acc(1, 1, 32'h80, 32'h0BADF00D, 32'h77777777, 3, 4, 1);
    chk("rw_rdata_unchanged", {33'h0, rdata_o}, {33'h0, 32'hCAFEF00D});
`ifdef MEM_MISALIGN_CHECK_EN
    do_acc(1, 0, 32'h102, 32'h0, 32'h11111111, 1, 1, 0);
    chk("mis_rdata_unchanged", {33'h0, rdata_o}, {33'h0, 32'hCAFEF00D});
`else
    do_acc(1, 0, 32'h102, 32'h0, 32'h11111111, 1, 2, 1);
    chk("mis_off_rdata", {33'h0, rdata_o}, {33'h0, 32'h11111111});
`endif
    mem_read_i = 1'b1; addr_i = 32'h300; wdata_i = 32'h99999999;
    req_q.push_back({1'b0, 32'h300, 32'h99999999});
    repeat (3) @(posedge clk);
    #1 reset = 1'b1; mem_read_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset_vals();
    @(posedge clk); #1;
    do_acc(1, 0, 32'h10, 32'h0, 32'hA5A5A5A5, 1, 2, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("req_q_drained", 65'(req_q.size()), 65'h0);
    chk("rd_q_drained", 65'(rd_q.size()), 65'h0);
    chk("mis_drained", 65'(exp_mis), 65'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
